// File: rtl/lcd_rgb_rx_if.sv
// LCD RGB receiver bus: TFT strobes and pixel in, line-buffer writes and status out.
interface lcd_rgb_rx_if;
    logic        i_HSD;
    logic        i_VSD;
    logic        i_DEN;
    logic [7:0]  i_R;
    logic [7:0]  i_G;
    logic [7:0]  i_B;
    logic        o_WrEn;
    logic [9:0]  o_WrAddr;
    logic [15:0] o_Data;
    logic [9:0]  o_YPx;
    logic        o_LineDone;
    logic        o_FrameDone;
    logic        o_ErrLine;
    logic        o_ErrFrame;
    logic        o_Locked;

    modport master (
        output i_HSD, i_VSD, i_DEN, i_R, i_G, i_B,
        input  o_WrEn, o_WrAddr, o_Data, o_YPx,
        input  o_LineDone, o_FrameDone, o_ErrLine, o_ErrFrame, o_Locked
    );

    modport slave (
        input  i_HSD, i_VSD, i_DEN, i_R, i_G, i_B,
        output o_WrEn, o_WrAddr, o_Data, o_YPx,
        output o_LineDone, o_FrameDone, o_ErrLine, o_ErrFrame, o_Locked
    );
endinterface

// File: rtl/lcd_rgb_rx.sv
// TFT RGB receiver: recovers x/y from VSD/DEN, packs RGB565 line-buffer writes,
// checks line/frame geometry and tracks lock.
module lcd_rgb_rx #(
    parameter int H_ACTIVE      = 800,
    parameter int V_ACTIVE      = 480,
    parameter int LOCK_FRAMES   = 2,
    parameter int FRAME_TIMEOUT = 1048575
) (
    input  logic       i_CLK,
    input  logic       i_Reset,
    lcd_rgb_rx_if.slave bus
);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [10:0]   H_MAX  = 11'(H_ACTIVE);
    localparam logic [9:0]    V_MAX  = 10'(V_ACTIVE);
    localparam logic [TW-1:0] T_LAST = TW'(FRAME_TIMEOUT - 1);
    localparam logic [GW-1:0] G_MAX  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_e;

    state_e        state_q, state_d;
    logic          vsd_q, den_q;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          ovr_q, ovr_d;
    logic          lerr_q, lerr_d;
    logic          ferr_q, ferr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] good_q, good_d;
    logic          wren_q, wren_d;
    logic [9:0]    addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic [9:0]    ypx_q, ypx_d;
    logic          ld_q, ld_d;
    logic          fd_q, fd_d;
    logic          el_q, el_d;
    logic          ef_q, ef_d;
    logic          lock_q, lock_d;

    logic        vsd_fall, den_rise, fbad;
    logic [15:0] pix;

    always_comb begin
        vsd_fall = vsd_q & ~bus.i_VSD;
        den_rise = bus.i_DEN & ~den_q;
        pix      = {bus.i_R[7:3], bus.i_G[7:2], bus.i_B[7:3]};
        fbad     = 1'b0;
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        ovr_d    = ovr_q;
        lerr_d   = lerr_q;
        ferr_d   = ferr_q;
        timer_d  = timer_q;
        good_d   = good_q;
        wren_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        ld_d     = 1'b0;
        fd_d     = 1'b0;
        el_d     = 1'b0;
        ef_d     = 1'b0;

        if (state_q == S_IDLE) begin
            if (vsd_fall) begin
                state_d = S_WAIT;
                y_d     = '0;
                timer_d = '0;
                ferr_d  = 1'b0;
            end
        end else if (vsd_fall) begin
            // Frame boundary aborts any line in progress without a write.
            fbad    = (y_q != V_MAX) || bus.i_DEN;
            fd_d    = 1'b1;
            ef_d    = fbad;
            if (fbad || ferr_q)
                good_d = '0;
            else if (good_q < G_MAX)
                good_d = good_q + 1'b1;
            state_d = S_WAIT;
            x_d     = '0;
            y_d     = '0;
            ferr_d  = 1'b0;
            timer_d = '0;
        end else if (timer_q == T_LAST) begin
            state_d = S_IDLE;
            good_d  = '0;
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
            unique case (state_q)
                S_WAIT: begin
                    if (den_rise) begin
                        state_d = S_ACTIVE;
                        x_d     = 11'd1;
                        lerr_d  = 1'b0;
                        ovr_d   = (y_q >= V_MAX);
                        if (y_q < V_MAX) begin
                            wren_d = 1'b1;
                            addr_d = '0;
                            data_d = pix;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (bus.i_DEN) begin
                        if (x_q >= H_MAX) begin
                            lerr_d = 1'b1;
                        end else if (!ovr_q) begin
                            wren_d = 1'b1;
                            addr_d = x_q[9:0];
                            data_d = pix;
                        end
                        if (x_q < H_MAX)
                            x_d = x_q + 1'b1;
                    end else begin
                        ld_d    = 1'b1;
                        state_d = S_WAIT;
                        if ((x_q != H_MAX) || lerr_q || ovr_q) begin
                            el_d   = 1'b1;
                            good_d = '0;
                            ferr_d = 1'b1;
                        end
                        if (y_q != 10'h3FF)
                            y_d = y_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        ypx_d  = wren_d ? y_q : ypx_q;
        lock_d = (good_d >= G_MAX);
    end

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            vsd_q   <= 1'b1;
            den_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ovr_q   <= 1'b0;
            lerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            timer_q <= '0;
            good_q  <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ypx_q   <= '0;
            ld_q    <= 1'b0;
            fd_q    <= 1'b0;
            el_q    <= 1'b0;
            ef_q    <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vsd_q   <= bus.i_VSD;
            den_q   <= bus.i_DEN;
            x_q     <= x_d;
            y_q     <= y_d;
            ovr_q   <= ovr_d;
            lerr_q  <= lerr_d;
            ferr_q  <= ferr_d;
            timer_q <= timer_d;
            good_q  <= good_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ypx_q   <= ypx_d;
            ld_q    <= ld_d;
            fd_q    <= fd_d;
            el_q    <= el_d;
            ef_q    <= ef_d;
            lock_q  <= lock_d;
        end
    end

    assign bus.o_WrEn      = wren_q;
    assign bus.o_WrAddr    = addr_q;
    assign bus.o_Data      = data_q;
    assign bus.o_YPx       = ypx_q;
    assign bus.o_LineDone  = ld_q;
    assign bus.o_FrameDone = fd_q;
    assign bus.o_ErrLine   = el_q;
    assign bus.o_ErrFrame  = ef_q;
    assign bus.o_Locked    = lock_q;
endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx with an 8x4 geometry, lock of 2 frames, 64-cycle timeout.
module tb_lcd_rgb_rx;
    logic clk = 1'b0;
    logic i_Reset;
    always #5 clk = ~clk;

    lcd_rgb_rx_if bus ();

    lcd_rgb_rx #(
        .H_ACTIVE(8), .V_ACTIVE(4), .LOCK_FRAMES(2), .FRAME_TIMEOUT(64)
    ) dut (
        .i_CLK  (clk),
        .i_Reset(i_Reset),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int wr_cnt = 0, ld_cnt = 0, fd_cnt = 0, el_cnt = 0, ef_cnt = 0;
    int hi_cnt = 0, bad_data = 0, el_locked = 0;
    int cyc_n = 0, last_fd_cyc = 0, unlock_cyc = 0;
    logic [31:0] mask = '0;
    logic prev_lock = 1'b0;
    logic [15:0] exp_data = 16'hFFFF;

    int s_wr, s_ld, s_fd, s_el, s_ef, s_hi;

    always @(posedge clk) begin
        cyc_n++;
        #1;
        if (bus.o_WrEn) begin
            wr_cnt++;
            if (bus.o_Data != exp_data) bad_data++;
            if (bus.o_WrAddr < 10'd8 && bus.o_YPx < 10'd4)
                mask[{bus.o_YPx[1:0], bus.o_WrAddr[2:0]}] = 1'b1;
            else
                hi_cnt++;
        end
        if (bus.o_LineDone) ld_cnt++;
        if (bus.o_FrameDone) begin
            fd_cnt++;
            last_fd_cyc = cyc_n;
        end
        if (bus.o_ErrLine) el_cnt++;
        if (bus.o_ErrFrame) ef_cnt++;
        if (bus.o_ErrLine && bus.o_Locked) el_locked++;
        if (prev_lock && !bus.o_Locked) unlock_cyc = cyc_n;
        prev_lock = bus.o_Locked;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_wr = wr_cnt; s_ld = ld_cnt; s_fd = fd_cnt;
        s_el = el_cnt; s_ef = ef_cnt; s_hi = hi_cnt;
    endtask

    task automatic line(input int n, input int gap);
        bus.i_DEN = 1'b1;
        repeat (n) @(negedge clk);
        bus.i_DEN = 1'b0;
        bus.i_HSD = 1'b0;
        @(negedge clk);
        bus.i_HSD = 1'b1;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic vsync();
        bus.i_VSD = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_VSD = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d);
        line(a, 4);
        line(b, 4);
        line(c, 4);
        line(d, 4);
        vsync();
    endtask

    initial begin
        i_Reset   = 1'b1;
        bus.i_HSD = 1'b1;
        bus.i_VSD = 1'b1;
        bus.i_DEN = 1'b0;
        bus.i_R   = 8'hF8;
        bus.i_G   = 8'hFC;
        bus.i_B   = 8'hF8;
        repeat (3) @(negedge clk);
        chk("rst_wren", 32'(bus.o_WrEn), 0);
        chk("rst_lock", 32'(bus.o_Locked), 0);
        chk("rst_addr", 32'(bus.o_WrAddr), 0);
        chk("rst_data", 32'(bus.o_Data), 0);
        i_Reset = 1'b0;
        @(negedge clk);

        // three clean frames
        vsync();
        snap();
        frame4(8, 8, 8, 8);
        chk("p1_lock_fd1", 32'(bus.o_Locked), 0);
        frame4(8, 8, 8, 8);
        chk("p1_lock_fd2", 32'(bus.o_Locked), 1);
        frame4(8, 8, 8, 8);
        chk("p1_wr", 32'(wr_cnt - s_wr), 96);
        chk("p1_ld", 32'(ld_cnt - s_ld), 12);
        chk("p1_fd", 32'(fd_cnt - s_fd), 3);
        chk("p1_el", 32'(el_cnt - s_el), 0);
        chk("p1_ef", 32'(ef_cnt - s_ef), 0);
        chk("p1_mask", mask, 32'hFFFF_FFFF);

        // short line inside a locked frame
        snap();
        frame4(8, 7, 8, 8);
        chk("p2_wr", 32'(wr_cnt - s_wr), 31);
        chk("p2_el", 32'(el_cnt - s_el), 1);
        chk("p2_ld", 32'(ld_cnt - s_ld), 4);
        chk("p2_ef", 32'(ef_cnt - s_ef), 0);
        chk("p2_lock", 32'(bus.o_Locked), 0);
        frame4(8, 8, 8, 8);
        chk("p2_relock1", 32'(bus.o_Locked), 0);
        frame4(8, 8, 8, 8);
        chk("p2_relock2", 32'(bus.o_Locked), 1);

        // long line
        snap();
        frame4(8, 10, 8, 8);
        chk("p3_wr", 32'(wr_cnt - s_wr), 32);
        chk("p3_el", 32'(el_cnt - s_el), 1);
        chk("p3_hi", 32'(hi_cnt - s_hi), 0);

        // five-line frame
        snap();
        for (int i = 0; i < 5; i++) line(8, 2);
        vsync();
        chk("p3b_wr", 32'(wr_cnt - s_wr), 32);
        chk("p3b_el", 32'(el_cnt - s_el), 1);
        chk("p3b_ld", 32'(ld_cnt - s_ld), 5);
        chk("p3b_ef", 32'(ef_cnt - s_ef), 1);

        // VSD falls while DEN high at x=3
        snap();
        bus.i_DEN = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_VSD = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_VSD = 1'b1;
        bus.i_DEN = 1'b0;
        repeat (2) @(negedge clk);
        chk("p4_wr", 32'(wr_cnt - s_wr), 3);
        chk("p4_ld", 32'(ld_cnt - s_ld), 0);
        chk("p4_fd", 32'(fd_cnt - s_fd), 1);
        chk("p4_ef", 32'(ef_cnt - s_ef), 1);
        bus.i_DEN = 1'b1;
        @(posedge clk);
        #1;
        chk("p4_nx_wren", 32'(bus.o_WrEn), 1);
        chk("p4_nx_addr", 32'(bus.o_WrAddr), 0);
        chk("p4_nx_y", 32'(bus.o_YPx), 0);
        @(negedge clk);
        repeat (7) @(negedge clk);
        bus.i_DEN = 1'b0;
        repeat (4) @(negedge clk);

        // RGB565 packing
        exp_data  = 16'h11AA;
        bus.i_R   = 8'h12;
        bus.i_G   = 8'h34;
        bus.i_B   = 8'h56;
        bus.i_DEN = 1'b1;
        @(posedge clk);
        #1;
        chk("p5_wren", 32'(bus.o_WrEn), 1);
        chk("p5_data", 32'(bus.o_Data), 32'h11AA);
        @(negedge clk);
        bus.i_DEN = 1'b0;
        bus.i_R   = 8'hF8;
        bus.i_G   = 8'hFC;
        bus.i_B   = 8'hF8;
        exp_data  = 16'hFFFF;
        repeat (4) @(negedge clk);

        // timeout after lock
        vsync();
        frame4(8, 8, 8, 8);
        frame4(8, 8, 8, 8);
        chk("p6_locked", 32'(bus.o_Locked), 1);
        repeat (70) @(negedge clk);
        chk("p6_tmo_cyc", 32'(unlock_cyc - last_fd_cyc), 64);
        chk("p6_lock0", 32'(bus.o_Locked), 0);
        snap();
        line(8, 4);
        chk("p6_idle_wr", 32'(wr_cnt - s_wr), 0);
        snap();
        vsync();
        line(8, 4);
        chk("p6_first_fd", 32'(fd_cnt - s_fd), 0);
        chk("p6_resume_wr", 32'(wr_cnt - s_wr), 8);

        // reset mid-line
        bus.i_DEN = 1'b1;
        repeat (3) @(negedge clk);
        chk("p7_pre_wren", 32'(bus.o_WrEn), 1);
        i_Reset = 1'b1;
        @(posedge clk);
        #1;
        chk("p7_rst_wren", 32'(bus.o_WrEn), 0);
        @(negedge clk);
        i_Reset   = 1'b0;
        bus.i_DEN = 1'b0;
        repeat (2) @(negedge clk);

        chk("all_data", 32'(bad_data), 0);
        chk("el_locked", 32'(el_locked), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_rgb_rx.md
Name: lcd_rgb_rx

Overview:
- Receiver for the parallel TFT RGB interface that tftlcd drives (HSD/VSD/DEN plus 24-bit RGB).
- Recovers pixel x/y coordinates from the sync and enable strobes.
- Packs each pixel back to RGB565 and emits blockram-compatible line-buffer write strobes.
- Checks line and frame geometry. Used for LCD-path loopback capture and as the bench-side monitor for the display pipeline.

Parameters:
- H_ACTIVE, 800, active pixels per line (DEN-high cycles)
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive error-free frames required before o_Locked asserts
- FRAME_TIMEOUT, 1048575, cycles without a VSD falling edge before returning to idle

Ports:
- i_CLK  in  1  pixel clock (LCDCLK domain)
- i_Reset  in  1  synchronous active-high reset
- i_HSD  in  1  horizontal sync, active low
- i_VSD  in  1  vertical sync, active low
- i_DEN  in  1  data enable, active high
- i_R  in  8  red
- i_G  in  8  green
- i_B  in  8  blue
- o_WrEn  out  1  line-buffer write strobe
- o_WrAddr  out  10  pixel x coordinate (line-buffer address)
- o_Data  out  16  pixel, RGB565 = {R[7:3], G[7:2], B[7:3]}
- o_YPx  out  10  current line y
- o_LineDone  out  1  one-cycle pulse at end of each active line
- o_FrameDone  out  1  one-cycle pulse at each frame boundary
- o_ErrLine  out  1  one-cycle pulse: line pixel count != H_ACTIVE, or line beyond V_ACTIVE
- o_ErrFrame  out  1  one-cycle pulse: frame line count != V_ACTIVE, or DEN high at VSD edge
- o_Locked  out  1  geometry locked

Behaviour:
- Single clock i_CLK. Reset synchronous, active high. All outputs registered.
- Reset values: all outputs 0, state S_IDLE, counters 0, previous-sample registers of VSD/DEN set to 1/0.
- Edge detection:
  - VSD falling edge = prev_VSD 1 and i_VSD 0.
  - DEN rise/fall are computed against prev_DEN.
  - i_HSD is not used for counting; DEN defines lines.
- Latency: a pixel sampled at clock edge k drives o_WrEn/o_WrAddr/o_Data after edge k. Exactly one write per accepted pixel.
- S_IDLE:
  - no writes
  - VSD falling edge -> S_WAIT, y=0, frame timer cleared
  - no FrameDone for this first edge
- S_WAIT (between lines):
  - DEN rise with y < V_ACTIVE -> S_ACTIVE, write pixel at x=0
  - DEN rise with y >= V_ACTIVE -> S_ACTIVE, overrun flag set, no writes for that line
- S_ACTIVE:
  - while DEN is high: write at x, x+1 saturates at H_ACTIVE
  - pixels with x >= H_ACTIVE are not written; they set the line-error flag
  - DEN fall -> o_LineDone pulse; o_ErrLine pulse if count != H_ACTIVE or overrun; y increments (saturates at 1023); -> S_WAIT
- VSD falling edge in S_WAIT or S_ACTIVE:
  - o_FrameDone pulse
  - o_ErrFrame if y != V_ACTIVE, or if DEN is high on that cycle
  - a line in progress is aborted: its pixel on that cycle is not written and no LineDone is issued
  - y=0 -> S_WAIT
  - if DEN is also rising, the new line starts on the next DEN rise only
- o_YPx reflects y at write time.
- Lock:
  - Good-frame counter increments on error-free FrameDone, saturating at LOCK_FRAMES.
  - o_Locked = counter >= LOCK_FRAMES.
  - Any o_ErrLine or o_ErrFrame clears the counter and o_Locked in the same cycle as the pulse.
- Timeout:
  - Frame timer counts every cycle outside S_IDLE and clears on each VSD falling edge.
  - On reaching FRAME_TIMEOUT: -> S_IDLE, o_Locked=0, counter=0, no pulses.
- Reset mid-frame returns to S_IDLE next cycle. Writes stop immediately.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4. Drive 3 clean frames (4 lines × 8 DEN cycles, 4-cycle gaps, VSD low 2 cycles) with R=0xF8, G=0xFC, B=0xF8 -> 32 writes per frame, addr 0..7, y 0..3, o_Data=0xFFFF, 4 LineDone per frame, o_Locked=1 after the 2nd FrameDone.
- Line with 7 DEN cycles in a locked frame -> 7 writes, o_ErrLine pulse at DEN fall, o_Locked drops the same cycle, relocks after 2 clean frames.
- Line with 10 DEN cycles -> only addr 0..7 written, o_ErrLine pulse; 5th line in a frame -> zero writes plus o_ErrLine; frame with 5 lines -> o_ErrFrame at the VSD edge.
- VSD falls while DEN high at x=3 -> writes 0..2 only, no LineDone, o_FrameDone and o_ErrFrame pulse, next DEN rise writes x=0 y=0.
- Pixel R=0x12, G=0x34, B=0x56 -> o_Data=0x11AA one cycle after sampling.
- FRAME_TIMEOUT=64 with VSD held high after lock -> o_Locked=0 at cycle 64, subsequent DEN produces no writes until a VSD falling edge; i_Reset asserted mid-line -> o_WrEn 0 next cycle.
